// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: a WIDTH-bit add sequenced through one 4-bit slice,
// LS nibble first, with the slice carry registered between cycles.

module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             ovf_q, ovf_d;
   logic             load;

   logic [3:0]       slice_sum;
   logic             slice_cout;

   adder_4bit u_slice (
      .a    (a_sh_q[3:0]),
      .b    (b_sh_q[3:0]),
      .cin  (c_q),
      .s    (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      load    = 1'b0;

      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: load = start;
            S_ADD: begin
               // acc shifts right so the newest slice lands in the MS nibble
               acc_d              = acc_q >> 4;
               acc_d[WIDTH-1 -: 4] = slice_sum;
               a_sh_d             = a_sh_q >> 4;
               b_sh_d             = b_sh_q >> 4;
               c_d                = slice_cout;
               cnt_d              = cnt_q + CW'(1);
               if (cnt_q == CW'(NIB - 1)) begin
                  sum_d   = acc_d;
                  ovf_d   = slice_cout;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               load    = start;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         if (load) begin
            state_d = S_ADD;
            a_sh_d  = a;
            b_sh_d  = b;
            c_d     = carry_in;
            cnt_d   = '0;
            acc_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == S_ADD);
   assign done     = (state_q == S_DONE);
   assign sum      = sum_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder at WIDTH 4, 16 and 32
// against plain a+b+cin arithmetic.

module tb_nibble_serial_adder;

   logic clk;
   logic n_rst;

   logic        st4, clr4, ci4, busy4, done4, ovf4;
   logic [3:0]  a4, b4, sum4;
   logic        st16, clr16, ci16, busy16, done16, ovf16;
   logic [15:0] a16, b16, sum16;
   logic        st32, clr32, ci32, busy32, done32, ovf32;
   logic [31:0] a32, b32, sum32;

   int checks;
   int failures;

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .n_rst(n_rst), .start(st4), .clear(clr4), .a(a4), .b(b4),
      .carry_in(ci4), .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
   );

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .n_rst(n_rst), .start(st16), .clear(clr16), .a(a16), .b(b16),
      .carry_in(ci16), .busy(busy16), .done(done16), .sum(sum16), .overflow(ovf16)
   );

   nibble_serial_adder #(.WIDTH(32)) dut32 (
      .clk(clk), .n_rst(n_rst), .start(st32), .clear(clr32), .a(a32), .b(b32),
      .carry_in(ci32), .busy(busy32), .done(done32), .sum(sum32), .overflow(ovf32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One complete add on the 16-bit instance, inputs scrambled after the start edge
   task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [16:0] r;
      r = {1'b0, x} + {1'b0, y} + {16'd0, c};
      a16 = x; b16 = y; ci16 = c; st16 = 1'b1;
      tick();
      st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      chk("op16_busy", 64'(busy16), 64'd1);
      for (int i = 1; i < 4; i++) tick();
      chk("op16_early_done", 64'(done16), 64'd0);
      tick();
      chk("op16_done", 64'(done16), 64'd1);
      chk("op16_sum", 64'(sum16), 64'(r[15:0]));
      chk("op16_ovf", 64'(ovf16), 64'(r[16]));
      chk("op16_busy_off", 64'(busy16), 64'd0);
      tick();
      chk("op16_done_pulse", 64'(done16), 64'd0);
   endtask

   task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic c);
      logic [32:0] r;
      r = {1'b0, x} + {1'b0, y} + {32'd0, c};
      a32 = x; b32 = y; ci32 = c; st32 = 1'b1;
      tick();
      st32 = 1'b0; a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
      chk("op32_busy", 64'(busy32), 64'd1);
      for (int i = 1; i < 8; i++) tick();
      chk("op32_early_done", 64'(done32), 64'd0);
      tick();
      chk("op32_done", 64'(done32), 64'd1);
      chk("op32_sum", 64'(sum32), 64'(r[31:0]));
      chk("op32_ovf", 64'(ovf32), 64'(r[32]));
      tick();
   endtask

   task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [4:0] r;
      r = {1'b0, x} + {1'b0, y} + {4'd0, c};
      a4 = x; b4 = y; ci4 = c; st4 = 1'b1;
      tick();
      st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
      chk("op4_busy", 64'(busy4), 64'd1);
      chk("op4_early_done", 64'(done4), 64'd0);
      tick();
      chk("op4_done", 64'(done4), 64'd1);
      chk("op4_sum", 64'(sum4), 64'(r[3:0]));
      chk("op4_ovf", 64'(ovf4), 64'(r[4]));
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      n_rst = 1'b0;
      {st4, clr4, ci4, a4, b4} = '0;
      {st16, clr16, ci16, a16, b16} = '0;
      {st32, clr32, ci32, a32, b32} = '0;

      #12;
      chk("rst_busy", 64'(busy16), 64'd0);
      chk("rst_done", 64'(done16), 64'd0);
      chk("rst_sum", 64'(sum16), 64'd0);
      chk("rst_ovf", 64'(ovf16), 64'd0);
      n_rst = 1'b1;
      tick();

      // Basic adds, full ripple carry and carry_in propagation
      op16(16'h1234, 16'h4321, 1'b0);
      op16(16'hFFFF, 16'h0001, 1'b0);
      op16(16'h00FF, 16'h0000, 1'b1);

      // Start during ADD is ignored; start held in DONE runs back-to-back
      a16 = 16'h1234; b16 = 16'h4321; ci16 = 1'b0; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      tick();
      a16 = 16'h1111; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      chk("ign_busy", 64'(busy16), 64'd1);
      chk("ign_done", 64'(done16), 64'd0);
      tick();
      chk("ign_done2", 64'(done16), 64'd0);
      tick();
      chk("ign_done3", 64'(done16), 64'd1);
      chk("ign_sum", 64'(sum16), 64'h5555);
      a16 = 16'h0001; b16 = 16'h0001; ci16 = 1'b0; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      chk("b2b_busy", 64'(busy16), 64'd1);
      chk("b2b_done_off", 64'(done16), 64'd0);
      for (int i = 1; i < 4; i++) tick();
      chk("b2b_early_done", 64'(done16), 64'd0);
      tick();
      chk("b2b_done", 64'(done16), 64'd1);
      chk("b2b_sum", 64'(sum16), 64'h0002);
      tick();

      // Asynchronous reset in the middle of an add
      a16 = 16'hAAAA; b16 = 16'h0001; ci16 = 1'b0; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      tick();
      tick();
      n_rst = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy16), 64'd0);
      chk("mid_rst_done", 64'(done16), 64'd0);
      chk("mid_rst_sum", 64'(sum16), 64'd0);
      chk("mid_rst_ovf", 64'(ovf16), 64'd0);
      tick();
      n_rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_no_done", 64'(done16), 64'd0);
      end
      chk("post_rst_sum", 64'(sum16), 64'd0);

      // Clear mid-add keeps the previous result
      op16(16'h1234, 16'h4321, 1'b0);
      a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      tick();
      tick();
      clr16 = 1'b1;
      tick();
      clr16 = 1'b0;
      chk("clr_busy", 64'(busy16), 64'd0);
      chk("clr_done", 64'(done16), 64'd0);
      chk("clr_sum", 64'(sum16), 64'h5555);
      chk("clr_ovf", 64'(ovf16), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_clr_no_done", 64'(done16), 64'd0);
      end

      // Clear on the completing edge wins over completion
      a16 = 16'h0F0F; b16 = 16'h0101; ci16 = 1'b0; st16 = 1'b1;
      tick();
      st16 = 1'b0;
      tick(); tick(); tick();
      clr16 = 1'b1;
      tick();
      clr16 = 1'b0;
      chk("clr_last_done", 64'(done16), 64'd0);
      chk("clr_last_sum", 64'(sum16), 64'h5555);

      // Single-nibble instance
      op4(4'hF, 4'h1, 1'b1);
      for (int i = 0; i < 100; i++)
         op4(4'($urandom), 4'($urandom), 1'($urandom));

      for (int i = 0; i < 1000; i++)
         op16(16'($urandom), 16'($urandom), 1'($urandom));
      for (int i = 0; i < 1000; i++)
         op32($urandom, $urandom, 1'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
